// File: rtl/stream_rx_buffer.sv
// Receive-side stream buffer: valid-only input, ready/valid first-word fall-through output.
// Define STREAM_RX_BUFFER_DROP_CNT_EN to add the 16-bit saturating o_drop_count output.
module stream_rx_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1024
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [WIDTH-1:0]       i_in_data,
  input  logic                   i_in_valid,
  output logic [WIDTH-1:0]       o_out_data,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [$clog2(DEPTH):0] o_fill_level,
  output logic                   o_overflow,
  input  logic                   i_clear_overflow
`ifdef STREAM_RX_BUFFER_DROP_CNT_EN
  ,
  output logic [15:0]            o_drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] FULL = FW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [FW-1:0]    mem_count;
  logic             wr_en;
  logic             drop;
  logic             xfer;
  logic             load;

  // The fill level includes the word held in the output register, so the
  // RAM occupancy is the fill level minus that register's valid bit.
  always_comb begin
    mem_count = o_fill_level - FW'(o_out_valid);
    wr_en     = i_in_valid && (o_fill_level < FULL);
    drop      = i_in_valid && (o_fill_level == FULL);
    xfer      = o_out_valid && i_out_ready;
    load      = (mem_count != '0) && (!o_out_valid || i_out_ready);
  end

  always_ff @(posedge i_clock) begin
    if (wr_en && !i_reset) begin
      mem[wr_ptr] <= i_in_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_out_valid  <= 1'b0;
      o_out_data   <= '0;
      o_fill_level <= '0;
      o_overflow   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      // A transfer and a refill in the same cycle keep the output streaming.
      if (load) begin
        rd_ptr      <= rd_ptr + 1'b1;
        o_out_data  <= mem[rd_ptr];
        o_out_valid <= 1'b1;
      end else if (xfer) begin
        o_out_valid <= 1'b0;
      end
      o_fill_level <= o_fill_level + FW'(wr_en) - FW'(xfer);
      if (drop) begin
        o_overflow <= 1'b1;
      end else if (i_clear_overflow) begin
        o_overflow <= 1'b0;
      end
    end
  end

`ifdef STREAM_RX_BUFFER_DROP_CNT_EN
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_drop_count <= '0;
    end else if (drop) begin
      if (i_clear_overflow) begin
        o_drop_count <= 16'd1;
      end else if (o_drop_count != '1) begin
        o_drop_count <= o_drop_count + 16'd1;
      end
    end else if (i_clear_overflow) begin
      o_drop_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_stream_rx_buffer.sv
// Bench for stream_rx_buffer (WIDTH=8, DEPTH=4): directed vector table, streaming run,
// and randomized traffic against a queue-based reference model.
module tb_stream_rx_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv;
  logic [7:0] id;
  logic       rdy;
  logic       clr;
  logic [7:0] od;
  logic       ov;
  logic [2:0] fill;
  logic       ovf;
`ifdef STREAM_RX_BUFFER_DROP_CNT_EN
  logic [15:0] dcnt;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  stream_rx_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_in_data        (id),
    .i_in_valid       (iv),
    .o_out_data       (od),
    .o_out_valid      (ov),
    .i_out_ready      (rdy),
    .o_fill_level     (fill),
    .o_overflow       (ovf),
    .i_clear_overflow (clr)
`ifdef STREAM_RX_BUFFER_DROP_CNT_EN
    ,
    .o_drop_count     (dcnt)
`endif
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [7:0]  id;
    logic        rdy;
    logic        clr;
    logic        ev;
    logic [7:0]  ed;
    logic [2:0]  ef;
    logic        eo;
    logic [15:0] edc;
  } vec_t;

  vec_t vecs[$];

  typedef struct {
    logic [7:0]  d;
    int unsigned t;
  } ent_t;

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic rd,
                     input logic cl, input logic ev, input logic [7:0] ed,
                     input logic [2:0] ef, input logic eo, input logic [15:0] edc);
    vec_t x;
    x.rst = r; x.iv = v; x.id = d; x.rdy = rd; x.clr = cl;
    x.ev = ev; x.ed = ed; x.ef = ef; x.eo = eo; x.edc = edc;
    vecs.push_back(x);
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic step(input logic r, input logic v, input logic [7:0] d,
                      input logic rd, input logic cl);
    @(negedge clk);
    rst = r; iv = v; id = d; rdy = rd; clr = cl;
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [7:0] ed,
                         input logic [2:0] ef, input logic eo, input logic [15:0] edc);
    chk({tag, " valid"}, 32'(ov), 32'(ev));
    chk({tag, " data"}, 32'(od), 32'(ed));
    chk({tag, " fill"}, 32'(fill), 32'(ef));
    chk({tag, " overflow"}, 32'(ovf), 32'(eo));
`ifdef STREAM_RX_BUFFER_DROP_CNT_EN
    chk({tag, " drop_count"}, 32'(dcnt), 32'(edc));
`else
    if (edc == 16'hFFFF) $display("note: unused drop expectation");
`endif
  endtask

  initial begin
    ent_t        q[$];
    logic [7:0]  last_d;
    logic        m_ovf;
    logic [15:0] m_cnt;
    int unsigned cyc;
    logic        ev;
    logic [7:0]  ed;
    logic        r, v, rd, cl, dropped;
    logic [7:0]  d;
    int unsigned piv[6] = '{90, 90, 30, 100, 70, 50};
    int unsigned prd[6] = '{90, 30, 90, 100, 50, 70};

    rst = 1'b1; iv = 1'b0; id = '0; rdy = 1'b0; clr = 1'b0;
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);

    // reset held with input present: ignored
    add(1,1,8'h55,1,0, 0,8'h00,0,0,0);
    // single word into empty buffer
    add(0,1,8'hA5,1,0, 0,8'h00,0,0,0);
    add(0,0,8'h00,1,0, 0,8'h00,1,0,0);
    add(0,0,8'h00,1,0, 1,8'hA5,1,0,0);
    add(0,0,8'h00,1,0, 0,8'hA5,0,0,0);
    // overfill with ready low, then drain
    add(0,1,8'h01,0,0, 0,8'hA5,0,0,0);
    add(0,1,8'h02,0,0, 0,8'hA5,1,0,0);
    add(0,1,8'h03,0,0, 1,8'h01,2,0,0);
    add(0,1,8'h04,0,0, 1,8'h01,3,0,0);
    add(0,1,8'h05,0,0, 1,8'h01,4,0,0);
    add(0,1,8'h06,0,0, 1,8'h01,4,1,1);
    add(0,0,8'h00,1,0, 1,8'h01,4,1,2);
    add(0,0,8'h00,1,0, 1,8'h02,3,1,2);
    add(0,0,8'h00,1,0, 1,8'h03,2,1,2);
    add(0,0,8'h00,1,0, 1,8'h04,1,1,2);
    add(0,0,8'h00,0,1, 0,8'h04,0,1,2);
    // drop at full alongside a transfer; clear coinciding with a drop
    add(0,1,8'h11,0,0, 0,8'h04,0,0,0);
    add(0,1,8'h12,0,0, 0,8'h04,1,0,0);
    add(0,1,8'h13,0,0, 1,8'h11,2,0,0);
    add(0,1,8'h14,0,0, 1,8'h11,3,0,0);
    add(0,1,8'h15,1,0, 1,8'h11,4,0,0);
    add(0,0,8'h00,0,0, 1,8'h12,3,1,1);
    add(0,1,8'h16,0,0, 1,8'h12,3,1,1);
    add(0,1,8'h17,0,1, 1,8'h12,4,1,1);
    add(0,0,8'h00,0,1, 1,8'h12,4,1,1);
    add(0,0,8'h00,1,0, 1,8'h12,4,0,0);
    add(0,0,8'h00,1,0, 1,8'h13,3,0,0);
    add(0,0,8'h00,1,0, 1,8'h14,2,0,0);
    add(0,0,8'h00,1,0, 1,8'h16,1,0,0);
    add(0,0,8'h00,0,0, 0,8'h16,0,0,0);
    // ready 1,0,0,1 stall with three words held
    add(0,1,8'h31,0,0, 0,8'h16,0,0,0);
    add(0,1,8'h32,0,0, 0,8'h16,1,0,0);
    add(0,1,8'h33,0,0, 1,8'h31,2,0,0);
    add(0,0,8'h00,1,0, 1,8'h31,3,0,0);
    add(0,0,8'h00,0,0, 1,8'h32,2,0,0);
    add(0,0,8'h00,0,0, 1,8'h32,2,0,0);
    add(0,0,8'h00,1,0, 1,8'h32,2,0,0);
    add(0,0,8'h00,1,0, 1,8'h33,1,0,0);
    add(0,0,8'h00,0,0, 0,8'h33,0,0,0);
    // mid-operation reset discards contents and overflow
    add(0,1,8'h21,0,0, 0,8'h33,0,0,0);
    add(0,1,8'h22,0,0, 0,8'h33,1,0,0);
    add(0,1,8'h23,0,0, 1,8'h21,2,0,0);
    add(0,1,8'h24,0,0, 1,8'h21,3,0,0);
    add(0,1,8'h25,0,0, 1,8'h21,4,0,0);
    add(1,1,8'h99,1,0, 1,8'h21,4,1,1);
    add(0,0,8'h00,1,0, 0,8'h00,0,0,0);
    add(0,1,8'h7E,1,0, 0,8'h00,0,0,0);
    add(0,0,8'h00,1,0, 0,8'h00,1,0,0);
    add(0,0,8'h00,1,0, 1,8'h7E,1,0,0);
    add(0,0,8'h00,1,0, 0,8'h7E,0,0,0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].iv, vecs[i].id, vecs[i].rdy, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ef, vecs[i].eo,
              vecs[i].edc);
    end

    // continuous 20-word stream: no gaps, constant fill, pointers wrap
    for (int i = 0; i < 24; i++) begin
      step(0, (i < 20), 8'(16 + i), 1, 0);
      if (i >= 2 && i <= 21) begin
        chk($sformatf("stream%0d valid", i), 32'(ov), 32'd1);
        chk($sformatf("stream%0d data", i), 32'(od), 32'(16 + i - 2));
      end
      if (i >= 2 && i <= 20) chk($sformatf("stream%0d fill", i), 32'(fill), 32'd2);
    end

    // randomized traffic against a model: a word is visible once it heads the
    // queue and at least two cycles have passed since it was accepted
    last_d = 8'h23; m_ovf = 1'b0; m_cnt = '0; cyc = 0;
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < 500; k++) begin
        r  = ($urandom_range(0, 299) == 0);
        v  = ($urandom_range(0, 99) < piv[p]);
        d  = 8'($urandom);
        rd = ($urandom_range(0, 99) < prd[p]);
        cl = ($urandom_range(0, 19) == 0);
        step(r, v, d, rd, cl);

        ev = (q.size() > 0) && (q[0].t + 2 <= cyc);
        if (ev) last_d = q[0].d;
        ed = last_d;
        chk_all("rand", ev, ed, 3'(q.size()), m_ovf, m_cnt);

        if (r) begin
          q.delete();
          last_d = 8'h00;
          m_ovf = 1'b0;
          m_cnt = '0;
        end else begin
          dropped = v && (q.size() == DEPTH);
          if (ev && rd) void'(q.pop_front());
          if (v && !dropped) q.push_back('{d: d, t: cyc});
          if (dropped) begin
            m_ovf = 1'b1;
            m_cnt = cl ? 16'd1 : ((m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1);
          end else if (cl) begin
            m_ovf = 1'b0;
            m_cnt = '0;
          end
        end
        cyc++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
